memory_bank_nr1w_init: RTL and testbench

Parametrised multi-read-port memory bank: NUM_READ_PORTS independent synchronous read ports and one byte-enabled write port. Per-port write-first/read-first selection, optional output register stage, per-port read-valid strobes and a hardware clear sequencer that fills the array with INIT_VALUE after reset or on request. It replaces the fixed two-read-port bank in caches, register files and directories that need three or more read ports or a guaranteed-clean array without a software sweep.

---
 rtl/memory_bank_pkg.sv | 11 +
 rtl/memory_bank_nr1w_init_if.sv | 38 +++
 rtl/memory_bank_nr1w_init_1r1w.sv | 64 ++++++
 rtl/memory_bank_nr1w_init.sv | 158 +++++++++++++++
 tb/tb_memory_bank_nr1w_init.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_bank_pkg.sv
// Shared types for the multi-read-port memory bank.
//   bank_state_t : CLEAR while the array is being filled with INIT_VALUE,
//                  READY while user reads and writes are accepted.
package memory_bank_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } bank_state_t;

endpackage

// File: rtl/memory_bank_nr1w_init_if.sv
// Bus bundle for memory_bank_nr1w_init.
//   init_start   : request a full clear (sampled only while ready)
//   ready        : bank accepts reads and writes
//   read_*       : NUM_READ_PORTS independent read ports (enable, address,
//                  data, single-cycle valid strobe)
//   write_*      : one byte-enabled write port shared by every read port
// master = requester side, slave = memory bank side.
interface memory_bank_nr1w_init_if #(
    parameter int unsigned NUM_READ_PORTS = 3,
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned NB_COL         = 4,
    parameter int unsigned COL_WIDTH      = 8
);
    localparam int unsigned W = NB_COL * COL_WIDTH;

    logic                                       init_start;
    logic                                       ready;
    logic [NUM_READ_PORTS-1:0]                  read_enable;
    logic [NUM_READ_PORTS-1:0][ADDR_WIDTH-1:0]  read_address;
    logic [NUM_READ_PORTS-1:0][W-1:0]           read_data;
    logic [NUM_READ_PORTS-1:0]                  read_valid;
    logic [NB_COL-1:0]                          write_enable;
    logic [ADDR_WIDTH-1:0]                      write_address;
    logic [W-1:0]                               write_data;

    modport master (
        output init_start, read_enable, read_address,
               write_enable, write_address, write_data,
        input  ready, read_data, read_valid
    );

    modport slave (
        input  init_start, read_enable, read_address,
               write_enable, write_address, write_data,
        output ready, read_data, read_valid
    );

endinterface

// File: rtl/memory_bank_nr1w_init_1r1w.sv
// memory_bank_1r1w: one synchronous read port, one byte-enabled write port.
//   clock, reset (async active-low, clears only the read data register)
//   write_enable/write_address/write_data : per-column write
//   read_enable/read_address              : read request
//   read_data                             : registered result, holds when idle
// WRITE_FIRST=1 returns the merged word on a same-address collision,
// WRITE_FIRST=0 returns the pre-write word.
module memory_bank_1r1w #(
    parameter int unsigned SIZE        = 1024,
    parameter int unsigned ADDR_WIDTH  = $clog2(SIZE),
    parameter int unsigned COL_WIDTH   = 8,
    parameter int unsigned NB_COL      = 4,
    parameter bit          WRITE_FIRST = 1'b1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NB_COL-1:0]             write_enable,
    input  logic [ADDR_WIDTH-1:0]         write_address,
    input  logic [NB_COL*COL_WIDTH-1:0]   write_data,
    input  logic                          read_enable,
    input  logic [ADDR_WIDTH-1:0]         read_address,
    output logic [NB_COL*COL_WIDTH-1:0]   read_data
);
    localparam int unsigned W = NB_COL * COL_WIDTH;

    logic [W-1:0] mem [SIZE];
    logic [W-1:0] old_word;
    logic [W-1:0] merged_word;
    logic [W-1:0] rdata_q, rdata_d;

    always_comb begin
        old_word    = mem[read_address];
        merged_word = old_word;
        for (int unsigned c = 0; c < NB_COL; c++) begin
            if (write_enable[c]) begin
                merged_word[c*COL_WIDTH +: COL_WIDTH] = write_data[c*COL_WIDTH +: COL_WIDTH];
            end
        end
        rdata_d = rdata_q;
        if (read_enable) begin
            // merged_word equals old_word when no column is enabled
            rdata_d = (WRITE_FIRST && (read_address == write_address)) ? merged_word : old_word;
        end
    end

    always_ff @(posedge clock) begin
        for (int unsigned c = 0; c < NB_COL; c++) begin
            if (write_enable[c]) begin
                mem[write_address][c*COL_WIDTH +: COL_WIDTH] <= write_data[c*COL_WIDTH +: COL_WIDTH];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign read_data = rdata_q;

endmodule

// File: rtl/memory_bank_nr1w_init.sv
// memory_bank_nr1w_init: NUM_READ_PORTS read ports, one byte-enabled write
// port, hardware clear sequencer.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset, restarts the clear from address 0
//   bus   : memory_bank_nr1w_init_if.slave (init_start/ready, read ports,
//           write port)
// After reset or init_start the array is filled with INIT_VALUE, one word per
// cycle; ready is low and user traffic is ignored until the fill completes.
module memory_bank_nr1w_init
    import memory_bank_pkg::*;
#(
    parameter int unsigned                          SIZE           = 1024,
    parameter int unsigned                          ADDR_WIDTH     = $clog2(SIZE),
    parameter int unsigned                          COL_WIDTH      = 8,
    parameter int unsigned                          NB_COL         = 4,
    parameter int unsigned                          NUM_READ_PORTS = 3,
    parameter logic [NUM_READ_PORTS-1:0]            WRITE_FIRST    = '1,
    parameter bit                                   OUTPUT_REG     = 1'b0,
    parameter logic [NB_COL*COL_WIDTH-1:0]          INIT_VALUE     = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    memory_bank_nr1w_init_if.slave  bus
);
    localparam int unsigned W = NB_COL * COL_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SIZE - 1);

    bank_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    ready_q, ready_d;

    logic [NB_COL-1:0]       mem_we;
    logic [ADDR_WIDTH-1:0]   mem_wa;
    logic [W-1:0]            mem_wd;
    logic [NUM_READ_PORTS-1:0]        rd_en;
    logic [NUM_READ_PORTS-1:0][W-1:0] bank_rdata;
    logic [NUM_READ_PORTS-1:0]        valid0_q, valid0_d;

    // Clear sequencer / FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        case (state_q)
            CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = READY;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            READY: begin
                if (bus.init_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // Shared write port: sequencer owns it in CLEAR, user in READY.
    // The user write on the init_start cycle still lands because state_q is
    // READY during that cycle.
    always_comb begin
        if (state_q == CLEAR) begin
            mem_we = '1;
            mem_wa = cnt_q;
            mem_wd = INIT_VALUE;
        end else begin
            mem_we = bus.write_enable;
            mem_wa = bus.write_address;
            mem_wd = bus.write_data;
        end
        rd_en    = bus.read_enable & {NUM_READ_PORTS{state_q == READY}};
        valid0_d = rd_en;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid0_q <= '0;
        end else begin
            valid0_q <= valid0_d;
        end
    end

    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
        memory_bank_1r1w #(
            .SIZE        (SIZE),
            .ADDR_WIDTH  (ADDR_WIDTH),
            .COL_WIDTH   (COL_WIDTH),
            .NB_COL      (NB_COL),
            .WRITE_FIRST (WRITE_FIRST[p])
        ) u_bank (
            .clock         (clock),
            .reset         (reset),
            .write_enable  (mem_we),
            .write_address (mem_wa),
            .write_data    (mem_wd),
            .read_enable   (rd_en[p]),
            .read_address  (bus.read_address[p]),
            .read_data     (bank_rdata[p])
        );
    end

    if (OUTPUT_REG) begin : g_oreg
        logic [NUM_READ_PORTS-1:0]        valid1_q, valid1_d;
        logic [NUM_READ_PORTS-1:0][W-1:0] data_q, data_d;

        always_comb begin
            valid1_d = valid0_q;
            data_d   = data_q;
            for (int unsigned p = 0; p < NUM_READ_PORTS; p++) begin
                if (valid0_q[p]) begin
                    data_d[p] = bank_rdata[p];
                end
            end
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                valid1_q <= '0;
                data_q   <= '0;
            end else begin
                valid1_q <= valid1_d;
                data_q   <= data_d;
            end
        end

        assign bus.read_valid = valid1_q;
        assign bus.read_data  = data_q;
    end else begin : g_noreg
        assign bus.read_valid = valid0_q;
        assign bus.read_data  = bank_rdata;
    end

    assign bus.ready = ready_q;

endmodule

// File: tb/tb_memory_bank_nr1w_init.sv
// Bench for memory_bank_nr1w_init: two instances (no output register / with
// output register) driven with identical traffic, checked by a scoreboard
// fed from a word-level reference model of the bank.
module tb_memory_bank_nr1w_init;

    localparam int unsigned SIZE = 16;
    localparam int unsigned AW   = 4;
    localparam int unsigned NP   = 3;
    localparam logic [31:0] INIT = 32'hA5A5A5A5;
    localparam logic [2:0]  WF   = 3'b101;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    memory_bank_nr1w_init_if #(.NUM_READ_PORTS(NP), .ADDR_WIDTH(AW), .NB_COL(4), .COL_WIDTH(8)) bus0 ();
    memory_bank_nr1w_init_if #(.NUM_READ_PORTS(NP), .ADDR_WIDTH(AW), .NB_COL(4), .COL_WIDTH(8)) bus1 ();

    memory_bank_nr1w_init #(
        .SIZE(SIZE), .ADDR_WIDTH(AW), .COL_WIDTH(8), .NB_COL(4), .NUM_READ_PORTS(NP),
        .WRITE_FIRST(WF), .OUTPUT_REG(1'b0), .INIT_VALUE(INIT)
    ) dut0 (.clock(clk), .reset(rst_n), .bus(bus0.slave));

    memory_bank_nr1w_init #(
        .SIZE(SIZE), .ADDR_WIDTH(AW), .COL_WIDTH(8), .NB_COL(4), .NUM_READ_PORTS(NP),
        .WRITE_FIRST(WF), .OUTPUT_REG(1'b1), .INIT_VALUE(INIT)
    ) dut1 (.clock(clk), .reset(rst_n), .bus(bus1.slave));

    // Observed signals gathered so the monitor can loop over instances
    logic [NP-1:0]        vld  [2];
    logic [NP-1:0][31:0]  rdat [2];
    logic                 rdy  [2];
    always_comb begin
        vld[0] = bus0.read_valid;  vld[1] = bus1.read_valid;
        rdat[0] = bus0.read_data;  rdat[1] = bus1.read_data;
        rdy[0] = bus0.ready;       rdy[1] = bus1.ready;
    end

    typedef struct {
        int          dut;
        int          port;
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [31:0] mem_m [SIZE];
    int          clear_left = SIZE;
    logic        rdy_exp = 1'b0;
    logic [31:0] last_data [2][NP];
    int          extra_lat [2] = '{0, 1};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int c = 0; c < 4; c++) if (we[c]) r[c*8 +: 8] = nw[c*8 +: 8];
        return r;
    endfunction

    // Reference model: effect of the coming rising edge, in spec terms
    task automatic model_edge(input logic [2:0] re, input logic [2:0][3:0] ra,
                              input logic [3:0] we, input logic [3:0] wa,
                              input logic [31:0] wd, input logic is);
        exp_t e;
        logic [31:0] v;
        if (clear_left == 0) begin
            for (int p = 0; p < NP; p++) begin
                if (re[p]) begin
                    v = mem_m[ra[p]];
                    if (WF[p] && ra[p] == wa) v = merge(v, wd, we);
                    for (int d = 0; d < 2; d++) begin
                        e.dut = d; e.port = p; e.data = v;
                        e.due = cyc + 1 + extra_lat[d];
                        sbq.push_back(e);
                    end
                end
            end
            mem_m[wa] = merge(mem_m[wa], wd, we);
            if (is) begin
                clear_left = SIZE;
                for (int a = 0; a < SIZE; a++) mem_m[a] = INIT;
            end
        end else begin
            clear_left--;
        end
        rdy_exp = (clear_left == 0);
    endtask

    task automatic step(input logic [2:0] re, input logic [2:0][3:0] ra, input logic [3:0] we,
                        input logic [3:0] wa, input logic [31:0] wd, input logic is);
        bus0.read_enable = re;  bus1.read_enable = re;
        bus0.read_address = ra; bus1.read_address = ra;
        bus0.write_enable = we; bus1.write_enable = we;
        bus0.write_address = wa; bus1.write_address = wa;
        bus0.write_data = wd;   bus1.write_data = wd;
        bus0.init_start = is;   bus1.init_start = is;
        model_edge(re, ra, we, wa, wd, is);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(3'b000, '0, 4'h0, 4'h0, 32'h0, 1'b0);
    endtask

    task automatic rd_all(input logic [3:0] a);
        step(3'b111, {a, a, a}, 4'h0, 4'h0, 32'h0, 1'b0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        sbq.delete();
        clear_left = SIZE;
        rdy_exp = 1'b0;
        for (int d = 0; d < 2; d++) for (int p = 0; p < NP; p++) last_data[d][p] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard whenever a port presents read_valid
    initial begin
        int idx;
        for (int d = 0; d < 2; d++) for (int p = 0; p < NP; p++) last_data[d][p] = '0;
        for (int a = 0; a < SIZE; a++) mem_m[a] = INIT;
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("ready[dut%0d]", d), {31'b0, rdy[d]}, {31'b0, rdy_exp});
                for (int p = 0; p < NP; p++) begin
                    if (vld[d][p]) begin
                        idx = -1;
                        for (int i = 0; i < sbq.size(); i++) begin
                            if (sbq[i].dut == d && sbq[i].port == p) begin
                                idx = i;
                                break;
                            end
                        end
                        if (idx < 0) begin
                            chk($sformatf("unexpected_valid[dut%0d.p%0d]", d, p), 32'd1, 32'd0);
                        end else begin
                            chk($sformatf("read_data[dut%0d.p%0d]", d, p), rdat[d][p], sbq[idx].data);
                            chk($sformatf("latency[dut%0d.p%0d]", d, p), 32'(cyc), 32'(sbq[idx].due));
                            last_data[d][p] = sbq[idx].data;
                            sbq.delete(idx);
                        end
                    end else begin
                        chk($sformatf("hold[dut%0d.p%0d]", d, p), rdat[d][p], last_data[d][p]);
                    end
                end
            end
            for (int i = sbq.size() - 1; i >= 0; i--) begin
                if (sbq[i].due <= cyc) begin
                    chk($sformatf("missing_valid[dut%0d.p%0d]", sbq[i].dut, sbq[i].port), 32'd0, 32'd1);
                    sbq.delete(i);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]       re;
        logic [2:0][3:0]  ra;
        logic [3:0]       we;
        step_init: begin
            bus0.read_enable = '0; bus1.read_enable = '0;
            bus0.read_address = '0; bus1.read_address = '0;
            bus0.write_enable = '0; bus1.write_enable = '0;
            bus0.write_address = '0; bus1.write_address = '0;
            bus0.write_data = '0; bus1.write_data = '0;
            bus0.init_start = 1'b0; bus1.init_start = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Power-up clear, then initial contents on all ports
        idle(SIZE);
        step(3'b111, {4'd15, 4'd7, 4'd0}, 4'h0, 4'h0, 32'h0, 1'b0);

        // Partial write collision: write-first vs read-first, then visibility
        step(3'b111, {4'd3, 4'd3, 4'd3}, 4'b0101, 4'd3, 32'h11223344, 1'b0);
        rd_all(4'd3);

        // Back-to-back reads on port 2
        step(3'b100, {4'd1, 4'd0, 4'd0}, 4'h0, 4'h0, 32'h0, 1'b0);
        step(3'b100, {4'd2, 4'd0, 4'd0}, 4'h0, 4'h0, 32'h0, 1'b0);
        step(3'b100, {4'd3, 4'd0, 4'd0}, 4'h0, 4'h0, 32'h0, 1'b0);

        // init_start clear; read on the last READY cycle returns pre-clear data
        step(3'b000, '0, 4'hF, 4'd5, 32'hDEADBEEF, 1'b0);
        step(3'b001, {4'd0, 4'd0, 4'd5}, 4'h0, 4'h0, 32'h0, 1'b1);
        for (int i = 0; i < SIZE; i++)
            step(3'b111, {4'd5, 4'd5, 4'd5}, 4'hF, 4'(i), 32'h0BADF00D, 1'b0);
        rd_all(4'd5);

        // Reset in the middle of a clear; writes during the clear are dropped
        step(3'b000, '0, 4'h0, 4'h0, 32'h0, 1'b1);
        for (int i = 0; i < 8; i++) step(3'b000, '0, 4'hF, 4'(i), 32'h12345678, 1'b0);
        apply_reset();
        for (int i = 0; i < SIZE; i++) step(3'b111, {4'(i), 4'(i), 4'(i)}, 4'hF, 4'(i), 32'h87654321, 1'b0);
        for (int a = 0; a < SIZE; a++) rd_all(4'(a));

        // Hold after a read
        step(3'b000, '0, 4'hF, 4'd9, 32'hCAFEF00D, 1'b0);
        rd_all(4'd9);
        idle(10);

        // Randomised traffic
        for (int i = 0; i < 500; i++) begin
            re = 3'($urandom);
            ra = 12'($urandom);
            we = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            step(re, ra, we, 4'($urandom), $urandom, ($urandom_range(0, 60) == 0));
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
